range_counter5: RTL and testbench

RANGE_COUNTER5 -- requirements
Module: range_counter5

---
 rtl/range_counter5_pkg.sv | 17 +
 rtl/Mux2to1.sv | 14 +
 rtl/reg5.sv | 26 ++
 rtl/range_counter5.sv | 118 +++++++++++
 tb/tb_range_counter5.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/range_counter5_pkg.sv
// Shared definitions for the range counter: default width and FSM state encoding.
package range_counter5_pkg;

    localparam int unsigned WIDTH_DEF = 5;
    localparam int unsigned STATE_W   = 3;
    localparam int unsigned SEL_BIT   = 2;

    // Bit 2 alone carries the mux select, so sel_out decodes glitch-free from one flop.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'b000,
        ST_LOAD_A = 3'b001,
        ST_DONE   = 3'b010,
        ST_LOAD_B = 3'b100,
        ST_COUNT  = 3'b101
    } state_t;

endpackage

// File: rtl/Mux2to1.sv
// Upstream 2:1 operand mux: sel=0 passes a, sel=1 passes b.
module Mux2to1 #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] c
);

    // Pure combinational select.
    assign c = sel ? b : a;

endmodule

// File: rtl/reg5.sv
// WIDTH-bit register with load enable, synchronous clear and async active-low reset.
module reg5
    import range_counter5_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/range_counter5.sv
// Loads start value a and end value b through an external 2:1 mux, then counts a..b modulo 2^WIDTH.
module range_counter5
    import range_counter5_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             step_en,
    input  logic [WIDTH-1:0] d_in,
    output logic             sel_out,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] limit_q;
    logic             cnt_ld;
    logic             lim_ld;
    logic             run_clr;
    logic             at_limit;

    assign at_limit = (cnt_q == limit_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and register controls; abort outranks every other transition while busy.
    always_comb begin
        state_nxt = state;
        cnt_ld    = 1'b0;
        cnt_d     = cnt_q;
        lim_ld    = 1'b0;
        run_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    run_clr   = 1'b1;
                end else begin
                    cnt_ld    = 1'b1;
                    cnt_d     = d_in;
                    state_nxt = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    run_clr   = 1'b1;
                end else begin
                    lim_ld    = 1'b1;
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    run_clr   = 1'b1;
                end else if (at_limit) begin
                    state_nxt = ST_DONE;
                end else if (step_en) begin
                    cnt_ld = 1'b1;
                    cnt_d  = cnt_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Count register: start value on load, +1 per enabled step, wraps silently.
    reg5 #(.WIDTH(WIDTH)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_clr),
        .load  (cnt_ld),
        .d     (cnt_d),
        .q     (cnt_q)
    );

    // Limit register: end value captured at the close of LOAD_B.
    reg5 #(.WIDTH(WIDTH)) u_limit (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_clr),
        .load  (lim_ld),
        .d     (d_in),
        .q     (limit_q)
    );

    // Status decodes straight from the state flops.
    assign sel_out = state[SEL_BIT];
    assign busy    = (state == ST_LOAD_A) || (state == ST_LOAD_B) || (state == ST_COUNT);
    assign done    = (state == ST_DONE);
    assign cnt     = cnt_q;

endmodule

// File: tb/tb_range_counter5.sv
// Scoreboard bench for range_counter5: each run pushes its expected per-cycle output trace,
// a monitor pops and compares one entry per clock.
module tb_range_counter5;

    localparam int W = 5;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         busy;
        logic         sel;
        logic         done;
    } exp_t;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic         start   = 1'b0;
    logic         abort   = 1'b0;
    logic         step_en = 1'b0;
    logic [W-1:0] op_a    = '0;
    logic [W-1:0] op_b    = '0;
    logic [W-1:0] d_in;
    logic [W-1:0] cnt;
    logic         sel_out;
    logic         busy;
    logic         done;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   last_cnt = 0;

    Mux2to1 #(.WIDTH(W)) u_mux (
        .a   (op_a),
        .b   (op_b),
        .sel (sel_out),
        .c   (d_in)
    );

    range_counter5 #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .step_en (step_en),
        .d_in    (d_in),
        .sel_out (sel_out),
        .cnt     (cnt),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input bit b, input bit s, input bit d);
        exp_t e;
        e.cnt  = W'(c);
        e.busy = b;
        e.sel  = s;
        e.done = d;
        return e;
    endfunction

    task automatic chk(input string nm, input int got, input int expv);
        n_assert++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, got, expv);
        end
    endtask

    // Monitor: one trace entry per cycle while a run is outstanding; otherwise done must stay low.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_assert++;
            if ({cnt, busy, sel_out, done} !== e) begin
                n_fail++;
                $display("FAIL trace @%0t: got cnt=%0d busy=%b sel=%b done=%b, expected cnt=%0d busy=%b sel=%b done=%b",
                         $time, cnt, busy, sel_out, done, e.cnt, e.busy, e.sel, e.done);
            end
        end else begin
            n_assert++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_done @%0t: got done=%b expected 0", $time, done);
            end
        end
    end

    // One run. mode 0: step always high, 1: random steps, 2: two stalls after the first step.
    // abort_ph/reset_ph index cycles from LOAD_A (0), LOAD_B (1), COUNT (2..); -1 none, -2 random abort.
    task automatic run(input int a, input int b, input int mode, input int abort_ph_in,
                       input int reset_ph, input bit glitch, input bit idle_abort);
        bit   sq[$];
        bit   sv[$];
        exp_t ev[$];
        int   n, ones, dph, last_ph, guard, abort_ph;
        bit   s;
        n = ((b - a) % 32 + 32) % 32;
        case (mode)
            0: repeat (n) sq.push_back(1'b1);
            2: sq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            default: begin
                ones = 0;
                while (ones < n) begin
                    s = ($urandom_range(3, 0) != 0);
                    sq.push_back(s);
                    if (s) ones++;
                end
            end
        endcase
        // Expected trace: LOAD_A, LOAD_B, COUNT cycles (cnt = a + steps taken so far), DONE, IDLE.
        ev.push_back(mk(last_cnt, 1, 0, 0)); sv.push_back(1'($urandom));
        ev.push_back(mk(a, 1, 1, 0));        sv.push_back(1'($urandom));
        ones = 0;
        for (int i = 0; i <= sq.size(); i++) begin
            ev.push_back(mk((a + ones) % 32, 1, 1, 0));
            if (i < sq.size()) begin
                sv.push_back(sq[i]);
                ones += int'(sq[i]);
            end else begin
                sv.push_back(1'($urandom));
            end
        end
        dph = ev.size();
        ev.push_back(mk(b, 0, 0, 1)); sv.push_back(1'($urandom));
        ev.push_back(mk(b, 0, 0, 0));
        last_ph  = dph;
        last_cnt = b;
        abort_ph = (abort_ph_in == -2) ? int'($urandom_range(dph - 1, 0)) : abort_ph_in;
        if (abort_ph >= 0) begin
            while (ev.size() > abort_ph + 1) void'(ev.pop_back());
            ev.push_back(mk(0, 0, 0, 0));
            ev.push_back(mk(0, 0, 0, 0));
            last_ph  = abort_ph;
            last_cnt = 0;
        end
        if (reset_ph >= 0) begin
            while (ev.size() > reset_ph + 1) void'(ev.pop_back());
            last_ph  = reset_ph - 1;
            last_cnt = 0;
        end

        @(negedge clk);
        op_a    = W'(a);
        op_b    = W'(b);
        start   = 1'b1;
        abort   = idle_abort;
        step_en = 1'($urandom);
        foreach (ev[k]) exp_q.push_back(ev[k]);
        for (int p = 0; p <= last_ph; p++) begin
            @(negedge clk);
            start   = glitch;
            step_en = sv[p];
            abort   = (p == abort_ph) || (p == dph && idle_abort);
        end
        if (reset_ph >= 0) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            #1;
            chk("async_rst_cnt", int'(cnt), 0);
            chk("async_rst_busy", int'(busy), 0);
            chk("async_rst_sel", int'(sel_out), 0);
            chk("async_rst_done", int'(done), 0);
            @(negedge clk);
            rst_n = 1'b1;
        end
        @(negedge clk);
        start   = 1'b0;
        abort   = 1'b0;
        step_en = 1'b0;
        guard   = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_assert++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending entries expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_cnt", int'(cnt), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sel", int'(sel_out), 0);
        chk("reset_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(3, 7, 0, -1, -1, 1'b0, 1'b0);
        run(9, 9, 0, -1, -1, 1'b0, 1'b0);
        run(30, 1, 0, -1, -1, 1'b0, 1'b0);
        run(0, 4, 2, -1, -1, 1'b1, 1'b0);
        run(2, 20, 0, 5, -1, 1'b0, 1'b0);
        run(6, 10, 0, -1, -1, 1'b0, 1'b1);
        run(5, 20, 0, -1, 8, 1'b0, 1'b0);
        run(12, 15, 1, -1, -1, 1'b0, 1'b0);
        run(31, 31, 1, 1, -1, 1'b1, 1'b0);
        run(17, 18, 1, 0, -1, 1'b0, 1'b1);
        repeat (30) begin
            run(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)), 1,
                ($urandom_range(3, 0) == 0) ? -2 : -1, -1,
                1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
